// File: rtl/window_sched_pkg.sv
// Shared definitions for the window computation actor scheduler and its firing FSM.
package window_sched_pkg;

  localparam int unsigned ModeW = 2;

  localparam logic [ModeW-1:0] MODE_SETUP_COMP = 2'b00;
  localparam logic [ModeW-1:0] MODE_COMP       = 2'b01;
  localparam logic [ModeW-1:0] MODE_OUTPUT     = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_HALT    = 3'd5
  } sched_state_t;

  // Ceiling log2, never below 1 so it can size a counter directly.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Mode sequence SETUP_COMP -> COMP -> OUTPUT -> SETUP_COMP.
  function automatic logic [ModeW-1:0] mode_next(input logic [ModeW-1:0] m);
    case (m)
      MODE_SETUP_COMP: return MODE_COMP;
      MODE_COMP:       return MODE_OUTPUT;
      default:         return MODE_SETUP_COMP;
    endcase
  endfunction

endpackage

// File: rtl/window_enable_check.sv
// Combinational CFDF enable decision: current mode vs. FIFO populations.
module window_enable_check
  import window_sched_pkg::*;
#(
  parameter int unsigned size      = 3,
  parameter int unsigned pop_width = 8
) (
  input  logic [ModeW-1:0]     mode_in,
  input  logic [pop_width-1:0] data_pop,
  input  logic [pop_width-1:0] len_pop,
  input  logic [pop_width-1:0] cmd_pop,
  input  logic [pop_width-1:0] out_free,
  output logic                 enable_c
);

  always_comb begin
    enable_c = 1'b0;
    case (mode_in)
      MODE_SETUP_COMP: enable_c = (data_pop >= pop_width'(size)) &&
                                  (len_pop  >= pop_width'(1)) &&
                                  (cmd_pop  >= pop_width'(1));
      MODE_COMP:       enable_c = 1'b1;
      MODE_OUTPUT:     enable_c = (out_free >= pop_width'(1));
      default:         enable_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/window_comp_scheduler.sv
// Enable/invoke scheduler for the window computation actor.
// Optional WAIT watchdog with sticky error/HALT: define WINDOW_SCHED_WATCHDOG_EN.
module window_comp_scheduler
  import window_sched_pkg::*;
#(
  parameter int unsigned size      = 3,
  parameter int unsigned pop_width = 8
`ifdef WINDOW_SCHED_WATCHDOG_EN
  ,
  parameter int unsigned wd_limit  = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_in,
  input  logic [pop_width-1:0] data_pop,
  input  logic [pop_width-1:0] len_pop,
  input  logic [pop_width-1:0] cmd_pop,
  input  logic [pop_width-1:0] out_free,
  input  logic [1:0]           length_in,
  input  logic [1:0]           command_in,
  input  logic                 fire_done_in,
  output logic                 fire_start_out,
  output logic [ModeW-1:0]     fire_mode_out,
  output logic [1:0]           length_out,
  output logic [1:0]           command_out,
  output logic                 len_rd_out,
  output logic                 cmd_rd_out,
  output logic                 busy_out,
  output logic                 error_out
);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [ModeW-1:0] r_mode;
  logic             w_enable;
  logic             r_fire_start;
  logic             r_pop;
  logic             r_busy;
  logic [1:0]       r_length;
  logic [1:0]       r_command;

  window_enable_check #(
    .size      (size),
    .pop_width (pop_width)
  ) u_enable_check (
    .mode_in  (r_mode),
    .data_pop (data_pop),
    .len_pop  (len_pop),
    .cmd_pop  (cmd_pop),
    .out_free (out_free),
    .enable_c (w_enable)
  );

`ifdef WINDOW_SCHED_WATCHDOG_EN
  localparam int unsigned WdW = log2(wd_limit);

  logic [WdW-1:0] r_wd_cnt;
  logic           r_error;
  logic           w_wd_expired;

  assign w_wd_expired = (r_wd_cnt == WdW'(wd_limit - 1));

  // Counts WAIT cycles; zero on the first WAIT cycle of each firing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      r_wd_cnt <= (r_state == ST_WAIT) ? r_wd_cnt + WdW'(1) : '0;
      if (w_state_nxt == ST_HALT) r_error <= 1'b1;
    end
  end

  assign error_out = r_error;
`else
  assign error_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (en_in) w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!en_in)        w_state_nxt = ST_IDLE;
        else if (w_enable) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH:  w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (fire_done_in) w_state_nxt = ST_ADVANCE;
`ifdef WINDOW_SCHED_WATCHDOG_EN
        else if (w_wd_expired) w_state_nxt = ST_HALT;
`endif
      end
      ST_ADVANCE: w_state_nxt = en_in ? ST_CHECK : ST_IDLE;
      ST_HALT:    w_state_nxt = ST_HALT;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode       <= MODE_SETUP_COMP;
      r_fire_start <= 1'b0;
      r_pop        <= 1'b0;
      r_busy       <= 1'b0;
      r_length     <= 2'b00;
      r_command    <= 2'b00;
    end else begin
      r_fire_start <= (w_state_nxt == ST_LAUNCH);
      r_pop        <= (w_state_nxt == ST_LAUNCH) && (r_mode == MODE_SETUP_COMP);
      r_busy       <= (w_state_nxt == ST_WAIT);
      if ((r_state == ST_LAUNCH) && (r_mode == MODE_SETUP_COMP)) begin
        r_length  <= length_in;
        r_command <= command_in;
      end
      if (r_state == ST_ADVANCE) r_mode <= mode_next(r_mode);
    end
  end

  assign fire_start_out = r_fire_start;
  assign fire_mode_out  = r_mode;
  assign length_out     = r_length;
  assign command_out    = r_command;
  assign len_rd_out     = r_pop;
  assign cmd_rd_out     = r_pop;
  assign busy_out       = r_busy;

endmodule

// File: tb/tb_window_comp_scheduler.sv
// Directed bench for window_comp_scheduler; watchdog checks follow WINDOW_SCHED_WATCHDOG_EN.
module tb_window_comp_scheduler;

  logic       clk;
  logic       rst;
  logic       en_in;
  logic [7:0] data_pop;
  logic [7:0] len_pop;
  logic [7:0] cmd_pop;
  logic [7:0] out_free;
  logic [1:0] length_in;
  logic [1:0] command_in;
  logic       fire_done_in;
  logic       fire_start_out;
  logic [1:0] fire_mode_out;
  logic [1:0] length_out;
  logic [1:0] command_out;
  logic       len_rd_out;
  logic       cmd_rd_out;
  logic       busy_out;
  logic       error_out;

  int n_cmp;
  int n_err;

  window_comp_scheduler #(
    .size      (3),
    .pop_width (8)
`ifdef WINDOW_SCHED_WATCHDOG_EN
    ,
    .wd_limit  (8)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en_in          (en_in),
    .data_pop       (data_pop),
    .len_pop        (len_pop),
    .cmd_pop        (cmd_pop),
    .out_free       (out_free),
    .length_in      (length_in),
    .command_in     (command_in),
    .fire_done_in   (fire_done_in),
    .fire_start_out (fire_start_out),
    .fire_mode_out  (fire_mode_out),
    .length_out     (length_out),
    .command_out    (command_out),
    .len_rd_out     (len_rd_out),
    .cmd_rd_out     (cmd_rd_out),
    .busy_out       (busy_out),
    .error_out      (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    en_in = 1'b1;
    data_pop = 8'd3;
    len_pop = 8'd1;
    cmd_pop = 8'd1;
    out_free = 8'd1;
    length_in = 2'd2;
    command_in = 2'd1;
    fire_done_in = 1'b0;

    tick(2);
    chk("rst_start", 8'(fire_start_out), 8'd0);
    chk("rst_busy",  8'(busy_out), 8'd0);
    chk("rst_err",   8'(error_out), 8'd0);
    chk("rst_mode",  8'(fire_mode_out), 8'd0);
    chk("rst_len",   8'(length_out), 8'd0);
    chk("rst_cmd",   8'(command_out), 8'd0);
    chk("rst_rd",    8'({len_rd_out, cmd_rd_out}), 8'd0);

    // SETUP_COMP firing: IDLE -> CHECK -> LAUNCH
    rst = 1'b1;
    tick(1);
    chk("check_nostart", 8'(fire_start_out), 8'd0);
    tick(1);
    chk("setup_start", 8'(fire_start_out), 8'd1);
    chk("setup_mode",  8'(fire_mode_out), 8'd0);
    chk("setup_rd",    8'({len_rd_out, cmd_rd_out}), 8'b11);
    tick(1);
    chk("setup_start_1cyc", 8'(fire_start_out), 8'd0);
    chk("setup_rd_1cyc",    8'({len_rd_out, cmd_rd_out}), 8'd0);
    chk("setup_busy",       8'(busy_out), 8'd1);
    chk("setup_len",        8'(length_out), 8'd2);
    chk("setup_cmd",        8'(command_out), 8'd1);
    length_in = 2'd3;
    command_in = 2'd0;
    tick(3);
    chk("wait_busy", 8'(busy_out), 8'd1);
    fire_done_in = 1'b1;
    tick(1);
    fire_done_in = 1'b0;
    chk("adv_busy", 8'(busy_out), 8'd0);
    chk("adv_mode", 8'(fire_mode_out), 8'd0);
    tick(1);
    chk("comp_check_mode", 8'(fire_mode_out), 8'd1);

    // COMP firing, always enabled, no pops
    tick(1);
    chk("comp_start", 8'(fire_start_out), 8'd1);
    chk("comp_mode",  8'(fire_mode_out), 8'd1);
    chk("comp_rd",    8'({len_rd_out, cmd_rd_out}), 8'd0);
    tick(1);
    chk("comp_len_hold", 8'(length_out), 8'd2);
    chk("comp_cmd_hold", 8'(command_out), 8'd1);
    out_free = 8'd0;
    tick(3);
    fire_done_in = 1'b1;
    tick(1);
    fire_done_in = 1'b0;
    tick(1);
    chk("out_check_mode", 8'(fire_mode_out), 8'd2);

    // OUTPUT blocked on zero free space
    for (int i = 0; i < 3; i++) begin
      chk("out_blocked", 8'(fire_start_out), 8'd0);
      tick(1);
    end
    out_free = 8'd1;
    tick(1);
    chk("out_start", 8'(fire_start_out), 8'd1);
    chk("out_mode",  8'(fire_mode_out), 8'd2);
    chk("out_len_hold", 8'(length_out), 8'd2);

    // Drop enable mid-firing: completes, advances, goes idle
    tick(1);
    en_in = 1'b0;
    tick(2);
    chk("noen_wait_busy", 8'(busy_out), 8'd1);
    fire_done_in = 1'b1;
    tick(1);
    fire_done_in = 1'b0;
    tick(1);
    chk("idle_busy", 8'(busy_out), 8'd0);
    chk("idle_mode", 8'(fire_mode_out), 8'd0);
    fire_done_in = 1'b1;
    tick(1);
    fire_done_in = 1'b0;
    tick(2);
    chk("idle_done_ignored_mode", 8'(fire_mode_out), 8'd0);
    chk("idle_nostart", 8'(fire_start_out), 8'd0);

    // Resume in SETUP_COMP with data_pop one short
    data_pop = 8'd2;
    en_in = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("setup_short", 8'(fire_start_out), 8'd0);
    end
    data_pop = 8'd3;
    tick(1);
    chk("setup2_start", 8'(fire_start_out), 8'd1);
    chk("setup2_mode",  8'(fire_mode_out), 8'd0);
    chk("setup2_rd",    8'({len_rd_out, cmd_rd_out}), 8'b11);
    tick(1);
    chk("setup2_len", 8'(length_out), 8'd3);
    chk("setup2_cmd", 8'(command_out), 8'd0);

    // Done never returned: first WAIT cycle is now
    tick(7);
    chk("wd_8th_wait_err", 8'(error_out), 8'd0);
    chk("wd_8th_wait_busy", 8'(busy_out), 8'd1);
    tick(1);
`ifdef WINDOW_SCHED_WATCHDOG_EN
    chk("wd_err", 8'(error_out), 8'd1);
    chk("wd_halt_busy", 8'(busy_out), 8'd0);
`else
    chk("nowd_err", 8'(error_out), 8'd0);
    chk("nowd_busy", 8'(busy_out), 8'd1);
`endif
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("stall_nostart", 8'(fire_start_out), 8'd0);
    end
`ifdef WINDOW_SCHED_WATCHDOG_EN
    chk("wd_err_sticky", 8'(error_out), 8'd1);
`else
    chk("nowd_err_late", 8'(error_out), 8'd0);
    chk("nowd_busy_late", 8'(busy_out), 8'd1);
`endif

    // Asynchronous reset mid-firing
    rst = 1'b0;
    #1;
    chk("arst_busy", 8'(busy_out), 8'd0);
    chk("arst_err",  8'(error_out), 8'd0);
    chk("arst_mode", 8'(fire_mode_out), 8'd0);
    chk("arst_len",  8'(length_out), 8'd0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/window_comp_scheduler.md
# window_comp_scheduler

CFDF enable/invoke scheduler for the window computation actor. It checks FIFO populations against the consumption and production rates of the current mode, then launches one firing of the level-2 firing-state FSM. It configures the actor by latching the length and command tokens, and advances the mode sequence SETUP_COMP → COMP → OUTPUT → SETUP_COMP. It sits between the top-level actor wrapper (FIFOs, run enable) and the firing FSM.

## Interface
Parameters:
- size, 3, tokens consumed from the data FIFO per SETUP_COMP firing
- pop_width, 8, bit width of the FIFO population/free-space counts
- wd_limit, 64, WAIT-state cycle limit (watchdog builds only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- en_in  in  1  run enable (level)
- data_pop  in  pop_width  data FIFO population
- len_pop  in  pop_width  length FIFO population
- cmd_pop  in  pop_width  command FIFO population
- out_free  in  pop_width  output FIFO free slots
- length_in  in  2  length FIFO head token
- command_in  in  2  command FIFO head token
- fire_done_in  in  1  done pulse from firing FSM
- fire_start_out  out  1  start pulse to firing FSM
- fire_mode_out  out  2  mode presented to firing FSM
- length_out  out  2  latched length
- command_out  out  2  latched command
- len_rd_out  out  1  length FIFO pop
- cmd_rd_out  out  1  command FIFO pop
- busy_out  out  1  firing in progress
- error_out  out  1  watchdog error, sticky

## Operation
- Mode codes: SETUP_COMP=2'b00, COMP=2'b01, OUTPUT=2'b10. The mode register resets to SETUP_COMP.
- Enable conditions per mode:
  - SETUP_COMP: data_pop ≥ size, len_pop ≥ 1 and cmd_pop ≥ 1.
  - COMP: always enabled.
  - OUTPUT: out_free ≥ 1.
  - Comparisons are unsigned. Equality counts as enabled.
- States:
  - IDLE: while en_in=1, go to CHECK.
  - CHECK: if en_in=0, go to IDLE. Else if the current mode is enabled, go to LAUNCH. Otherwise stay in CHECK.
  - LAUNCH: fire_start_out=1. In SETUP_COMP mode only, also len_rd_out=1 and cmd_rd_out=1, and length_out/command_out load from length_in/command_in. Go to WAIT.
  - WAIT: busy_out=1. On fire_done_in, go to ADVANCE.
  - ADVANCE: mode ← next in the sequence (OUTPUT wraps to SETUP_COMP). Then go to CHECK if en_in=1, else IDLE.
  - HALT: entered only in watchdog builds; left only by reset.
- fire_mode_out always equals the mode register, so it is stable from LAUNCH through WAIT.
- en_in=0 during WAIT does not abort the firing. The firing completes, the mode advances, then the FSM goes to IDLE. The mode is retained.
- fire_done_in outside WAIT is ignored.
- length_out/command_out hold their value until the next SETUP_COMP launch. They are valid for the COMP firing that follows.

## Timing
- Reset values:
  - state IDLE, mode SETUP_COMP
  - all pulse outputs 0, busy_out 0, error_out 0
  - length_out 0, command_out 0
- Latency: in CHECK with the mode enabled, fire_start_out is asserted the next cycle (LAUNCH). It is exactly 1 cycle wide.
- fire_done_in is sampled in WAIT. ADVANCE is the following cycle. The earliest next CHECK comes 1 cycle after ADVANCE.
- Minimum firing period is start-to-start = 4 cycles plus the firing FSM's latency.
- len_rd_out and cmd_rd_out coincide with fire_start_out. Pops assert only when the corresponding population is ≥ 1, which is guaranteed by the enable check.
- Reset mid-firing returns the block to IDLE/SETUP_COMP immediately. The firing FSM shares rst.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: WINDOW_SCHED_WATCHDOG_EN.
  - Defined: a WAIT-cycle counter resets on entry to WAIT. If it reaches wd_limit without fire_done_in, error_out←1 (sticky) and the state goes to HALT. No further starts are issued until reset.
  - Undefined: no counter, error_out tied 0, HALT unreachable.

## Structure
- Package window_sched_pkg holds:
  - the mode code constants, shared with the firing FSM
  - the state encodings
  - the log2 function
- Sub-module window_enable_check: combinational mode/population → enable decision, reusable by other actor schedulers.

## Test plan
- Reset with en_in=1, data_pop=3, len_pop=1, cmd_pop=1, length_in=2, command_in=1 → start pulse with mode 00, len_rd/cmd_rd=1 in the same cycle, length_out=2 and command_out=1.
- data_pop=2 in SETUP_COMP → stays in CHECK with no start. Raise data_pop to 3 → start on the next cycle.
- Full cycle with done returned 5 cycles after each start → modes observed in the order 00, 01, 10, 00. length_out is unchanged across the 01 and 10 firings.
- OUTPUT mode with out_free=0 → no start. Set out_free=1 → one start with mode 10.
- Drop en_in during WAIT → done is accepted, mode advances, block goes to IDLE with busy_out=0. Reassert en_in → resumes with the next mode.
- Watchdog build with wd_limit=8, done never returned → error_out=1 after 8 WAIT cycles, with no further starts. Non-watchdog build under the same stimulus → waits indefinitely with error_out=0.
